// File: rtl/spu_sched_pkg.sv
// Shared types and descriptor layout for the SPU softmax command scheduler.
// Descriptor fields are packed LSB first: six address fields, then the shifts.
package spu_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_ERR   = 3'd4
  } sched_state_e;

  localparam int N_ADDR_FIELDS = 6;
  localparam int SHI_W = 4;
  localparam int EXO_W = 5;
  localparam int SHO_W = 4;

  localparam int F_MY = 0;
  localparam int F_MX = 1;
  localparam int F_IM = 2;
  localparam int F_OM = 3;
  localparam int F_IA = 4;
  localparam int F_OA = 5;

  function automatic int desc_w(input int aw);
    return N_ADDR_FIELDS * aw + SHI_W + EXO_W + SHO_W;
  endfunction

  function automatic int addr_off(input int aw, input int idx);
    return idx * aw;
  endfunction

  function automatic int shi_off(input int aw);
    return N_ADDR_FIELDS * aw;
  endfunction

  function automatic int exo_off(input int aw);
    return shi_off(aw) + SHI_W;
  endfunction

  function automatic int sho_off(input int aw);
    return exo_off(aw) + EXO_W;
  endfunction

endpackage

// File: rtl/spu_cmd_fifo.sv
// Register FIFO for job descriptors with first-word-fall-through head.
// Pointers carry one extra wrap bit to tell full from empty.
module spu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[IW] != rd_q[IW]) &&
                 (wr_q[IW-1:0] == rd_q[IW-1:0]);

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_d = wr_q + PW'(do_push);
    rd_d = rd_q + PW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[IW-1:0]] <= din;
  end

  assign dout = mem_q[rd_q[IW-1:0]];

endmodule

// File: rtl/spu_sm_sched.sv
// Softmax job scheduler: queues descriptors, validates them, holds the
// engine configuration stable per job and supervises each run with a watchdog.
module spu_sm_sched
  import spu_sched_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT_W  = 20,
  parameter int DESC_W     = desc_w(ADDR_WIDTH)
) (
  input  logic                  core_clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DESC_W-1:0]     cmd_desc,
  input  logic [TIMEOUT_W-1:0]  timeout_limit,
  input  logic                  err_clr,
  output logic                  sm_start,
  input  logic                  sm_end,
  output logic [ADDR_WIDTH-1:0] spu_matrix_y,
  output logic [ADDR_WIDTH-1:0] spu_matrix_x,
  output logic [ADDR_WIDTH-1:0] im_base_addr,
  output logic [ADDR_WIDTH-1:0] om_base_addr,
  output logic [ADDR_WIDTH-1:0] ifm_addr_align,
  output logic [ADDR_WIDTH-1:0] ofm_addr_align,
  output logic [3:0]            sm_shift_input,
  output logic [4:0]            sm_exp_shift_output,
  output logic [3:0]            sm_shift_output,
  output logic                  busy,
  output logic                  job_done,
  output logic                  bad_desc,
  output logic                  timeout_err,
  output logic [15:0]           jobs_done_cnt
);

  localparam int AW    = ADDR_WIDTH;
  localparam int O_MY  = addr_off(AW, F_MY);
  localparam int O_MX  = addr_off(AW, F_MX);
  localparam int O_IM  = addr_off(AW, F_IM);
  localparam int O_OM  = addr_off(AW, F_OM);
  localparam int O_IA  = addr_off(AW, F_IA);
  localparam int O_OA  = addr_off(AW, F_OA);
  localparam int O_SHI = shi_off(AW);
  localparam int O_EXO = exo_off(AW);
  localparam int O_SHO = sho_off(AW);

  sched_state_e         state_q, state_d;
  logic [DESC_W-1:0]    cfg_q, cfg_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic [TIMEOUT_W-1:0] wd_inc;
  logic [15:0]          cnt_q, cnt_d;
  logic                 sm_start_q, sm_start_d;
  logic                 job_done_q, job_done_d;
  logic                 bad_desc_q, bad_desc_d;
  logic                 terr_q, terr_d;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic [DESC_W-1:0]    fifo_head;
  logic                 desc_bad;

  spu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DESC_W)
  ) u_fifo (
    .clk   (core_clk),
    .rst_n (rst_n),
    .push  (cmd_valid & cmd_ready),
    .pop   (fifo_pop),
    .din   (cmd_desc),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cmd_ready = ~fifo_full;

  // The engine consumes 4 elements per word, so x must be a non-zero multiple of 4.
  assign desc_bad = (spu_matrix_y == '0) ||
                    (spu_matrix_x[AW-1:2] == '0) ||
                    (spu_matrix_x[1:0] != 2'b00);

  assign wd_inc = wd_q + TIMEOUT_W'(1);

  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    wd_d       = wd_q;
    cnt_d      = cnt_q;
    sm_start_d = 1'b0;
    job_done_d = 1'b0;
    bad_desc_d = 1'b0;
    terr_d     = terr_q;
    fifo_pop   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cfg_d    = fifo_head;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        if (desc_bad) begin
          bad_desc_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          sm_start_d = 1'b1;
          state_d    = S_START;
        end
      end
      S_START: begin
        wd_d    = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        wd_d = wd_inc;
        // A completion in the limit cycle takes priority over the timeout.
        if (sm_end) begin
          job_done_d = 1'b1;
          cnt_d      = cnt_q + 16'd1;
          state_d    = S_IDLE;
        end else if (timeout_limit != '0 && wd_inc == timeout_limit) begin
          terr_d  = 1'b1;
          state_d = S_ERR;
        end
      end
      S_ERR: begin
        if (err_clr) begin
          terr_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        terr_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cfg_q      <= '0;
      wd_q       <= '0;
      cnt_q      <= '0;
      sm_start_q <= 1'b0;
      job_done_q <= 1'b0;
      bad_desc_q <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      wd_q       <= wd_d;
      cnt_q      <= cnt_d;
      sm_start_q <= sm_start_d;
      job_done_q <= job_done_d;
      bad_desc_q <= bad_desc_d;
      terr_q     <= terr_d;
    end
  end

  assign spu_matrix_y        = cfg_q[O_MY +: AW];
  assign spu_matrix_x        = cfg_q[O_MX +: AW];
  assign im_base_addr        = cfg_q[O_IM +: AW];
  assign om_base_addr        = cfg_q[O_OM +: AW];
  assign ifm_addr_align      = cfg_q[O_IA +: AW];
  assign ofm_addr_align      = cfg_q[O_OA +: AW];
  assign sm_shift_input      = cfg_q[O_SHI +: SHI_W];
  assign sm_exp_shift_output = cfg_q[O_EXO +: EXO_W];
  assign sm_shift_output     = cfg_q[O_SHO +: SHO_W];

  assign sm_start      = sm_start_q;
  assign job_done      = job_done_q;
  assign bad_desc      = bad_desc_q;
  assign timeout_err   = terr_q;
  assign jobs_done_cnt = cnt_q;
  assign busy          = (state_q != S_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_spu_sm_sched.sv
// Directed bench for spu_sm_sched: latency, queueing, validation,
// watchdog, err_clr recovery and asynchronous reset.
module tb_spu_sm_sched;

  localparam int AW = 12;
  localparam int DW = 6 * AW + 13;
  localparam int TW = 20;

  logic          core_clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] cmd_desc;
  logic [TW-1:0] timeout_limit;
  logic          err_clr;
  logic          sm_start;
  logic          sm_end;
  logic [AW-1:0] spu_matrix_y, spu_matrix_x;
  logic [AW-1:0] im_base_addr, om_base_addr;
  logic [AW-1:0] ifm_addr_align, ofm_addr_align;
  logic [3:0]    sm_shift_input;
  logic [4:0]    sm_exp_shift_output;
  logic [3:0]    sm_shift_output;
  logic          busy, job_done, bad_desc, timeout_err;
  logic [15:0]   jobs_done_cnt;

  int vecs = 0;
  int errs = 0;
  int n_start = 0;
  int n_bad = 0;

  spu_sm_sched dut (
    .core_clk            (core_clk),
    .rst_n               (rst_n),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_desc            (cmd_desc),
    .timeout_limit       (timeout_limit),
    .err_clr             (err_clr),
    .sm_start            (sm_start),
    .sm_end              (sm_end),
    .spu_matrix_y        (spu_matrix_y),
    .spu_matrix_x        (spu_matrix_x),
    .im_base_addr        (im_base_addr),
    .om_base_addr        (om_base_addr),
    .ifm_addr_align      (ifm_addr_align),
    .ofm_addr_align      (ofm_addr_align),
    .sm_shift_input      (sm_shift_input),
    .sm_exp_shift_output (sm_exp_shift_output),
    .sm_shift_output     (sm_shift_output),
    .busy                (busy),
    .job_done            (job_done),
    .bad_desc            (bad_desc),
    .timeout_err         (timeout_err),
    .jobs_done_cnt       (jobs_done_cnt)
  );

  logic [DW-1:0] cfg_out;
  logic [105:0]  all_out;

  assign cfg_out = {sm_shift_output, sm_exp_shift_output, sm_shift_input,
                    ofm_addr_align, ifm_addr_align, om_base_addr,
                    im_base_addr, spu_matrix_x, spu_matrix_y};
  assign all_out = {sm_start, job_done, bad_desc, timeout_err, busy,
                    jobs_done_cnt, cfg_out};

  initial begin
    core_clk = 1'b0;
    forever #5 core_clk = ~core_clk;
  end

  always @(negedge core_clk) begin
    if (sm_start) n_start++;
    if (bad_desc) n_bad++;
  end

  function automatic logic [DW-1:0] mk(
    input logic [AW-1:0] y, x, im, om, ia, oa,
    input logic [3:0] shi, input logic [4:0] exo, input logic [3:0] sho);
    return {sho, exo, shi, oa, ia, om, im, x, y};
  endfunction

  task automatic tick();
    @(posedge core_clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    int n;
    n = 0;
    cmd_desc  = d;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) begin
      vecs++; errs++;
      $display("FAIL push_timeout: cmd_ready=%b want 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (!sm_start && n < 60) begin
      tick();
      n++;
    end
    if (!sm_start) begin
      vecs++; errs++;
      $display("FAIL wait_start: sm_start=%b want 1", sm_start);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_desc = '0;
    timeout_limit = '0;
    err_clr = 1'b0;
    sm_end = 1'b0;
    #12;
    vecs++;
    if (all_out !== '0) begin
      errs++; $display("FAIL rst_outs: got %h want 0", all_out);
    end
    tick();
    rst_n = 1'b1;
    tick();
    vecs++;
    if (cmd_ready !== 1'b1) begin
      errs++; $display("FAIL rst_ready: got %b want 1", cmd_ready);
    end
    vecs++;
    if (all_out !== '0) begin
      errs++; $display("FAIL rst_idle: got %h want 0", all_out);
    end
  endtask

  task automatic test_single();
    logic [DW-1:0] d;
    d = mk(12'd2, 12'd16, 12'h100, 12'h200, 12'd4, 12'd4, 4'd3, 5'd7, 4'd2);
    push(d);
    tick();
    vecs++;
    if (sm_start !== 1'b0) begin
      errs++; $display("FAIL t1_load: sm_start=%b want 0", sm_start);
    end
    tick();
    vecs++;
    if (sm_start !== 1'b1) begin
      errs++; $display("FAIL t1_start: sm_start=%b want 1", sm_start);
    end
    vecs++;
    if (cfg_out !== d) begin
      errs++; $display("FAIL t1_cfg: got %h want %h", cfg_out, d);
    end
    vecs++;
    if (spu_matrix_x !== 12'd16 || im_base_addr !== 12'h100) begin
      errs++;
      $display("FAIL t1_fields: x=%h im=%h want 010 100",
               spu_matrix_x, im_base_addr);
    end
    repeat (17) tick();
    sm_end = 1'b1;
    tick();
    sm_end = 1'b0;
    vecs++;
    if ({job_done, busy, jobs_done_cnt} !== {1'b1, 1'b0, 16'd1}) begin
      errs++;
      $display("FAIL t1_done: done=%b busy=%b cnt=%0d want 1 0 1",
               job_done, busy, jobs_done_cnt);
    end
    tick();
    vecs++;
    if (job_done !== 1'b0 || cfg_out !== d) begin
      errs++;
      $display("FAIL t1_hold: done=%b cfg=%h want 0 %h", job_done, cfg_out, d);
    end
  endtask

  task automatic test_back_to_back();
    int gap;
    push(mk(12'd10, 12'd16, 0, 0, 0, 0, 0, 0, 0));
    wait_start(gap);
    for (int k = 1; k <= 4; k++) begin
      push(mk(AW'(10 + k), 12'd16, 0, 0, 0, 0, 0, 0, 0));
    end
    cmd_desc  = mk(12'd15, 12'd16, 0, 0, 0, 0, 0, 0, 0);
    cmd_valid = 1'b1;
    vecs++;
    if (cmd_ready !== 1'b0) begin
      errs++; $display("FAIL t2_full: cmd_ready=%b want 0", cmd_ready);
    end
    repeat (3) tick();
    vecs++;
    if (cmd_ready !== 1'b0 || sm_start !== 1'b0) begin
      errs++;
      $display("FAIL t2_held: ready=%b start=%b want 0 0", cmd_ready, sm_start);
    end
    sm_end = 1'b1;
    tick();
    sm_end = 1'b0;
    vecs++;
    if (job_done !== 1'b1 || cmd_ready !== 1'b0) begin
      errs++;
      $display("FAIL t2_end0: done=%b ready=%b want 1 0", job_done, cmd_ready);
    end
    tick();
    vecs++;
    if (cmd_ready !== 1'b1) begin
      errs++; $display("FAIL t2_popped: cmd_ready=%b want 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    vecs++;
    if (sm_start !== 1'b1 || spu_matrix_y !== 12'd11) begin
      errs++;
      $display("FAIL t2_job1: start=%b y=%0d want 1 11", sm_start, spu_matrix_y);
    end
    for (int k = 1; k <= 5; k++) begin
      tick();
      tick();
      sm_end = 1'b1;
      tick();
      sm_end = 1'b0;
      if (k < 5) begin
        gap = 1;
        while (!sm_start && gap < 20) begin
          tick();
          gap++;
        end
        vecs++;
        if (sm_start !== 1'b1 || gap != 3 || spu_matrix_y !== AW'(11 + k)) begin
          errs++;
          $display("FAIL t2_order: job %0d gap=%0d y=%0d want 3 %0d",
                   k + 1, gap, spu_matrix_y, 11 + k);
        end
      end
    end
    vecs++;
    if (jobs_done_cnt !== 16'd7 || busy !== 1'b0) begin
      errs++;
      $display("FAIL t2_count: cnt=%0d busy=%b want 7 0", jobs_done_cnt, busy);
    end
  endtask

  task automatic test_bad_desc();
    int b0, s0, n;
    b0 = n_bad;
    s0 = n_start;
    push(mk(12'd0, 12'd16, 0, 0, 0, 0, 0, 0, 0));
    push(mk(12'd2, 12'd6, 0, 0, 0, 0, 0, 0, 0));
    push(mk(12'd2, 12'd0, 0, 0, 0, 0, 0, 0, 0));
    push(mk(12'd3, 12'd4, 0, 0, 0, 0, 0, 0, 0));
    wait_start(n);
    vecs++;
    if (spu_matrix_y !== 12'd3 || spu_matrix_x !== 12'd4) begin
      errs++;
      $display("FAIL t3_valid: y=%0d x=%0d want 3 4", spu_matrix_y, spu_matrix_x);
    end
    tick();
    vecs++;
    if (n_bad - b0 != 3 || n_start - s0 != 1) begin
      errs++;
      $display("FAIL t3_pulses: bad=%0d start=%0d want 3 1",
               n_bad - b0, n_start - s0);
    end
    vecs++;
    if (jobs_done_cnt !== 16'd7) begin
      errs++; $display("FAIL t3_cnt_hold: got %0d want 7", jobs_done_cnt);
    end
    sm_end = 1'b1;
    tick();
    sm_end = 1'b0;
    vecs++;
    if (jobs_done_cnt !== 16'd8) begin
      errs++; $display("FAIL t3_cnt: got %0d want 8", jobs_done_cnt);
    end
  endtask

  task automatic test_timeout();
    int n, s0;
    timeout_limit = TW'(50);
    push(mk(12'd20, 12'd8, 0, 0, 0, 0, 0, 0, 0));
    push(mk(12'd21, 12'd8, 0, 0, 0, 0, 0, 0, 0));
    wait_start(n);
    repeat (50) tick();
    vecs++;
    if (timeout_err !== 1'b0) begin
      errs++; $display("FAIL t4_early: timeout_err=%b want 0", timeout_err);
    end
    tick();
    vecs++;
    if (timeout_err !== 1'b1) begin
      errs++; $display("FAIL t4_err: timeout_err=%b want 1", timeout_err);
    end
    sm_end = 1'b1;
    tick();
    sm_end = 1'b0;
    vecs++;
    if ({job_done, timeout_err, jobs_done_cnt} !== {1'b0, 1'b1, 16'd8}) begin
      errs++;
      $display("FAIL t4_late_end: done=%b err=%b cnt=%0d want 0 1 8",
               job_done, timeout_err, jobs_done_cnt);
    end
    s0 = n_start;
    repeat (3) tick();
    vecs++;
    if (n_start != s0 || spu_matrix_y !== 12'd20 || busy !== 1'b1) begin
      errs++;
      $display("FAIL t4_stall: starts=%0d y=%0d busy=%b want 0 20 1",
               n_start - s0, spu_matrix_y, busy);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    vecs++;
    if (timeout_err !== 1'b0) begin
      errs++; $display("FAIL t4_clr: timeout_err=%b want 0", timeout_err);
    end
    wait_start(n);
    vecs++;
    if (spu_matrix_y !== 12'd21 || n != 2) begin
      errs++;
      $display("FAIL t4_next: y=%0d lat=%0d want 21 2", spu_matrix_y, n);
    end
    tick();
    sm_end = 1'b1;
    tick();
    sm_end = 1'b0;
    vecs++;
    if (jobs_done_cnt !== 16'd9) begin
      errs++; $display("FAIL t4_cnt: got %0d want 9", jobs_done_cnt);
    end
  endtask

  task automatic test_end_at_limit();
    int n;
    timeout_limit = TW'(5);
    push(mk(12'd30, 12'd12, 0, 0, 0, 0, 0, 0, 0));
    wait_start(n);
    repeat (5) tick();
    vecs++;
    if (timeout_err !== 1'b0) begin
      errs++; $display("FAIL t5_pre: timeout_err=%b want 0", timeout_err);
    end
    sm_end = 1'b1;
    tick();
    sm_end = 1'b0;
    vecs++;
    if ({job_done, timeout_err, jobs_done_cnt} !== {1'b1, 1'b0, 16'd10}) begin
      errs++;
      $display("FAIL t5_race: done=%b err=%b cnt=%0d want 1 0 10",
               job_done, timeout_err, jobs_done_cnt);
    end
    tick();
    vecs++;
    if (timeout_err !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL t5_idle: err=%b busy=%b want 0 0", timeout_err, busy);
    end
    sm_end = 1'b1;
    tick();
    sm_end = 1'b0;
    vecs++;
    if ({job_done, busy, jobs_done_cnt} !== {1'b0, 1'b0, 16'd10}) begin
      errs++;
      $display("FAIL t5_spurious: done=%b busy=%b cnt=%0d want 0 0 10",
               job_done, busy, jobs_done_cnt);
    end
  endtask

  task automatic test_reset_mid_job();
    int n, s0;
    timeout_limit = '0;
    push(mk(12'd40, 12'd8, 0, 0, 0, 0, 0, 0, 0));
    push(mk(12'd41, 12'd8, 0, 0, 0, 0, 0, 0, 0));
    push(mk(12'd42, 12'd8, 0, 0, 0, 0, 0, 0, 0));
    wait_start(n);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    vecs++;
    if (all_out !== '0 || cmd_ready !== 1'b1) begin
      errs++;
      $display("FAIL t6_async: outs=%h ready=%b want 0 1", all_out, cmd_ready);
    end
    s0 = n_start;
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    vecs++;
    if (n_start != s0 || busy !== 1'b0 || jobs_done_cnt !== 16'd0) begin
      errs++;
      $display("FAIL t6_after: starts=%0d busy=%b cnt=%0d want 0 0 0",
               n_start - s0, busy, jobs_done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_bad_desc();
    test_timeout();
    test_end_at_limit();
    test_reset_mid_job();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
